// File: rtl/branch_resolve_unit.sv
// Branch resolution: flag forwarding, condition decode, registered redirect pulse and wrong-path squash.
// Optional performance counters are enabled with `define BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              id_valid,
    input  logic [1:0]        id_br_type,
    input  logic [3:0]        id_cond,
    input  logic              id_rt_zero,
    input  logic [ADDR_W-1:0] id_target,
    input  logic              ex_set_flags,
    input  logic [3:0]        ex_flags,
    input  logic [3:0]        reg_flags,
    output logic              br_taken,
    output logic [ADDR_W-1:0] br_target,
    output logic              flush_if,
`ifdef BRU_PERF_CNT_EN
    output logic [CNT_W-1:0]  br_resolved_cnt,
    output logic [CNT_W-1:0]  br_taken_cnt,
`endif
    output logic              squash_active
);

    typedef enum logic {IDLE, SQUASH} state_t;

    state_t            state_q, state_d;
    logic              br_taken_q;
    logic              flush_q;
    logic [ADDR_W-1:0] br_target_q;

    logic [3:0] eff;
    logic       f_n, f_z, f_c, f_v;
    logic       cond_true;
    logic       eval;
    logic       type_take;
    logic       take;

    // Handshake: an ID instruction is consumed only when id_valid=1, stall=0 and state is IDLE.
    always_comb begin
        eff = ex_set_flags ? ex_flags : reg_flags;
        {f_n, f_z, f_c, f_v} = eff;

        cond_true = 1'b0;
        case (id_cond)
            4'd0:    cond_true = f_z;
            4'd1:    cond_true = !f_z;
            4'd2:    cond_true = f_c;
            4'd3:    cond_true = !f_c;
            4'd4:    cond_true = f_n;
            4'd5:    cond_true = !f_n;
            4'd6:    cond_true = f_v;
            4'd7:    cond_true = !f_v;
            4'd8:    cond_true = f_c && !f_z;
            4'd9:    cond_true = !(f_c && !f_z);
            4'd10:   cond_true = (f_n == f_v);
            4'd11:   cond_true = (f_n != f_v);
            4'd12:   cond_true = !f_z && (f_n == f_v);
            4'd13:   cond_true = !(!f_z && (f_n == f_v));
            default: cond_true = 1'b1;
        endcase

        type_take = 1'b0;
        case (id_br_type)
            2'd1:    type_take = 1'b1;
            2'd2:    type_take = id_rt_zero;
            2'd3:    type_take = cond_true;
            default: type_take = 1'b0;
        endcase

        eval = (state_q == IDLE) && id_valid && !stall;
        take = eval && type_take;

        state_d = state_q;
        case (state_q)
            IDLE:    if (take)   state_d = SQUASH;
            SQUASH:  if (!stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A take always moves to SQUASH, so the pulse cannot repeat on the next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            br_taken_q  <= 1'b0;
            flush_q     <= 1'b0;
            br_target_q <= '0;
        end else begin
            state_q    <= state_d;
            br_taken_q <= take;
            flush_q    <= take;
            if (take) br_target_q <= id_target;
        end
    end

    assign br_taken      = br_taken_q;
    assign flush_if      = flush_q;
    assign br_target     = br_target_q;
    assign squash_active = (state_q == SQUASH);

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] resolved_cnt_q;
    logic [CNT_W-1:0] taken_cnt_q;

    // Saturating counters: hold at all-ones rather than wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resolved_cnt_q <= '0;
            taken_cnt_q    <= '0;
        end else begin
            if (eval && (id_br_type != 2'd0) && (resolved_cnt_q != '1))
                resolved_cnt_q <= resolved_cnt_q + 1'b1;
            if (take && (taken_cnt_q != '1))
                taken_cnt_q <= taken_cnt_q + 1'b1;
        end
    end

    assign br_resolved_cnt = resolved_cnt_q;
    assign br_taken_cnt    = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table plus reset, squash and counter sequences.
module tb_branch_resolve_unit;

    localparam int ADDR_W = 64;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              id_valid;
    logic [1:0]        id_br_type;
    logic [3:0]        id_cond;
    logic              id_rt_zero;
    logic [ADDR_W-1:0] id_target;
    logic              ex_set_flags;
    logic [3:0]        ex_flags;
    logic [3:0]        reg_flags;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              flush_if;
    logic              squash_active;
`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0]  br_resolved_cnt;
    logic [CNT_W-1:0]  br_taken_cnt;
`endif

    branch_resolve_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .id_valid      (id_valid),
        .id_br_type    (id_br_type),
        .id_cond       (id_cond),
        .id_rt_zero    (id_rt_zero),
        .id_target     (id_target),
        .ex_set_flags  (ex_set_flags),
        .ex_flags      (ex_flags),
        .reg_flags     (reg_flags),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .flush_if      (flush_if),
`ifdef BRU_PERF_CNT_EN
        .br_resolved_cnt(br_resolved_cnt),
        .br_taken_cnt  (br_taken_cnt),
`endif
        .squash_active (squash_active)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              valid;
        logic              stl;
        logic [1:0]        br_type;
        logic [3:0]        cond;
        logic              rt_zero;
        logic              set_flags;
        logic [3:0]        exf;
        logic [3:0]        regf;
        logic [ADDR_W-1:0] target;
        logic              exp_take;
    } tv_t;

    localparam int NV = 22;
    tv_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;
    logic [ADDR_W-1:0] exp_tgt;

    task automatic check(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall        = 1'b0;
        id_valid     = 1'b0;
        id_br_type   = 2'd0;
        id_cond      = 4'd0;
        id_rt_zero   = 1'b0;
        id_target    = '0;
        ex_set_flags = 1'b0;
        ex_flags     = 4'b0000;
        reg_flags    = 4'b0000;
    endtask

    task automatic drive_vec(input tv_t t);
        stall        = t.stl;
        id_valid     = t.valid;
        id_br_type   = t.br_type;
        id_cond      = t.cond;
        id_rt_zero   = t.rt_zero;
        id_target    = t.target;
        ex_set_flags = t.set_flags;
        ex_flags     = t.exf;
        reg_flags    = t.regf;
    endtask

    task automatic drive_b(input logic [ADDR_W-1:0] tgt);
        drive_idle();
        id_valid   = 1'b1;
        id_br_type = 2'd1;
        id_target  = tgt;
    endtask

    initial begin
        //                valid stall type  cond  rtz   setf  exf      regf     target                    take
        vecs[0]  = '{1'b1, 1'b0, 2'd3, 4'd0,  1'b0, 1'b1, 4'b0100, 4'b0000, 64'h40,                   1'b1};
        vecs[1]  = '{1'b1, 1'b0, 2'd3, 4'd0,  1'b0, 1'b0, 4'b0100, 4'b0000, 64'h44,                   1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'd3, 4'd11, 1'b0, 1'b0, 4'b0000, 4'b1000, 64'h200,                  1'b1};
        vecs[3]  = '{1'b1, 1'b0, 2'd3, 4'd10, 1'b0, 1'b0, 4'b0000, 4'b1000, 64'h204,                  1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'd3, 4'd13, 1'b0, 1'b0, 4'b0000, 4'b1000, 64'h300,                  1'b1};
        vecs[5]  = '{1'b1, 1'b0, 2'd3, 4'd12, 1'b0, 1'b0, 4'b0000, 4'b1001, 64'h400,                  1'b1};
        vecs[6]  = '{1'b1, 1'b0, 2'd2, 4'd0,  1'b1, 1'b0, 4'b0000, 4'b0000, 64'h100,                  1'b1};
        vecs[7]  = '{1'b1, 1'b0, 2'd2, 4'd0,  1'b0, 1'b0, 4'b0000, 4'b0000, 64'h104,                  1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 4'd14, 1'b1, 1'b0, 4'b0000, 4'b0000, 64'h108,                  1'b0};
        vecs[9]  = '{1'b1, 1'b0, 2'd1, 4'd0,  1'b0, 1'b0, 4'b0000, 4'b0000, 64'hFEDC_BA98_7654_3210,  1'b1};
        vecs[10] = '{1'b1, 1'b0, 2'd3, 4'd8,  1'b0, 1'b0, 4'b0000, 4'b0010, 64'h10,                   1'b1};
        vecs[11] = '{1'b1, 1'b0, 2'd3, 4'd9,  1'b0, 1'b0, 4'b0000, 4'b0110, 64'h20,                   1'b1};
        vecs[12] = '{1'b1, 1'b0, 2'd3, 4'd1,  1'b0, 1'b0, 4'b0000, 4'b0100, 64'h24,                   1'b0};
        vecs[13] = '{1'b1, 1'b0, 2'd3, 4'd15, 1'b0, 1'b0, 4'b0000, 4'b0000, 64'h30,                   1'b1};
        vecs[14] = '{1'b1, 1'b0, 2'd3, 4'd6,  1'b0, 1'b0, 4'b0000, 4'b0001, 64'h50,                   1'b1};
        vecs[15] = '{1'b1, 1'b0, 2'd3, 4'd4,  1'b0, 1'b1, 4'b0000, 4'b1000, 64'h54,                   1'b0};
        vecs[16] = '{1'b0, 1'b0, 2'd1, 4'd0,  1'b0, 1'b0, 4'b0000, 4'b0000, 64'h58,                   1'b0};
        vecs[17] = '{1'b1, 1'b1, 2'd1, 4'd0,  1'b0, 1'b0, 4'b0000, 4'b0000, 64'h5C,                   1'b0};
        vecs[18] = '{1'b1, 1'b0, 2'd3, 4'd5,  1'b0, 1'b0, 4'b0000, 4'b0000, 64'h60,                   1'b1};
        vecs[19] = '{1'b1, 1'b0, 2'd3, 4'd3,  1'b0, 1'b0, 4'b0000, 4'b0010, 64'h64,                   1'b0};
        vecs[20] = '{1'b1, 1'b0, 2'd3, 4'd7,  1'b0, 1'b0, 4'b0000, 4'b0000, 64'h70,                   1'b1};
        vecs[21] = '{1'b1, 1'b0, 2'd3, 4'd2,  1'b0, 1'b0, 4'b0000, 4'b0010, 64'h80,                   1'b1};

        drive_idle();
        reset = 1'b0;
        exp_tgt = '0;
        repeat (3) step();
        check("reset_br_taken", {63'd0, br_taken}, 0);
        check("reset_flush_if", {63'd0, flush_if}, 0);
        check("reset_br_target", br_target, 0);
        check("reset_squash", {63'd0, squash_active}, 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // table-driven vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_vec(vecs[i]);
            step();
            if (vecs[i].exp_take) exp_tgt = vecs[i].target;
            check($sformatf("v%0d_br_taken", i), {63'd0, br_taken}, {63'd0, vecs[i].exp_take});
            check($sformatf("v%0d_flush_if", i), {63'd0, flush_if}, {63'd0, vecs[i].exp_take});
            check($sformatf("v%0d_br_target", i), br_target, exp_tgt);
            check($sformatf("v%0d_squash", i), {63'd0, squash_active}, {63'd0, vecs[i].exp_take});
            if (vecs[i].exp_take) begin
                // wrong-path copy stays in ID during the squash cycle
                step();
                check($sformatf("v%0d_pulse_end", i), {63'd0, br_taken}, 0);
                check($sformatf("v%0d_flush_end", i), {63'd0, flush_if}, 0);
                check($sformatf("v%0d_squash_end", i), {63'd0, squash_active}, 0);
                check($sformatf("v%0d_target_hold", i), br_target, exp_tgt);
            end
            @(negedge clk);
            drive_idle();
            step();
        end

        // squash held by stall, with an AL branch waiting in ID
        @(negedge clk);
        drive_b(64'h500);
        step();
        check("sq_first_pulse", {63'd0, br_taken}, 1);
        check("sq_first_flush", {63'd0, flush_if}, 1);
        check("sq_first_target", br_target, 64'h500);
        check("sq_cycle1", {63'd0, squash_active}, 1);
        @(negedge clk);
        drive_idle();
        id_valid   = 1'b1;
        id_br_type = 2'd3;
        id_cond    = 4'd14;
        id_target  = 64'h900;
        stall      = 1'b1;
        step();
        check("sq_stall1_pulse", {63'd0, br_taken}, 0);
        check("sq_stall1_flush", {63'd0, flush_if}, 0);
        check("sq_cycle2", {63'd0, squash_active}, 1);
        step();
        check("sq_stall2_pulse", {63'd0, br_taken}, 0);
        check("sq_cycle3", {63'd0, squash_active}, 1);
        @(negedge clk);
        stall = 1'b0;
        step();
        check("sq_release_pulse", {63'd0, br_taken}, 0);
        check("sq_release_idle", {63'd0, squash_active}, 0);
        check("sq_target_kept", br_target, 64'h500);
        @(negedge clk);
        drive_idle();
        step();

        // asynchronous reset in the middle of a pulse
        @(negedge clk);
        drive_b(64'h777);
        step();
        check("rst_pre_pulse", {63'd0, br_taken}, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_br_taken", {63'd0, br_taken}, 0);
        check("rst_mid_flush_if", {63'd0, flush_if}, 0);
        check("rst_mid_br_target", br_target, 0);
        check("rst_mid_squash", {63'd0, squash_active}, 0);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        step();
        check("rst_after_squash", {63'd0, squash_active}, 0);
        @(negedge clk);
        id_valid   = 1'b1;
        id_br_type = 2'd3;
        id_cond    = 4'd14;
        id_target  = 64'hABC;
        step();
        check("rst_idle_take", {63'd0, br_taken}, 1);
        check("rst_idle_target", br_target, 64'hABC);
        @(negedge clk);
        drive_idle();
        step();

`ifdef BRU_PERF_CNT_EN
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("cnt_reset_resolved", {60'd0, br_resolved_cnt}, 0);
        check("cnt_reset_taken", {60'd0, br_taken_cnt}, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive_b(64'h1000 + 64'(i));
            step();
            @(negedge clk);
            drive_idle();
            step();
            if (i == 9) begin
                check("cnt_mid_resolved", {60'd0, br_resolved_cnt}, 10);
                check("cnt_mid_taken", {60'd0, br_taken_cnt}, 10);
            end
        end
        check("cnt_sat_resolved", {60'd0, br_resolved_cnt}, 15);
        check("cnt_sat_taken", {60'd0, br_taken_cnt}, 15);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Downstream consumer of the NZCV flag register; resolves conditional and unconditional branches for the pipelined core.
- Selects flags from the flag register or forwards them from the ALU when the EX-stage instruction sets flags.
- Registers the taken/target decision and issues a one-cycle fetch flush.
- Squashes the wrong-path instruction that follows a taken branch.

Parameters:
ADDR_W, 64, width of branch target address.
CNT_W, 16, width of performance counters (optional feature only).

Ports:
clk  input  1  core clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
stall  input  1  pipeline stall; ID instruction is not evaluated this cycle.
id_valid  input  1  ID stage holds a valid instruction.
id_br_type  input  2  0 none, 1 B (unconditional), 2 CBZ, 3 B.cond.
id_cond  input  4  B.cond condition code, ARM encoding.
id_rt_zero  input  1  CBZ operand equals zero.
id_target  input  ADDR_W  computed branch target.
ex_set_flags  input  1  EX instruction writes flags this cycle.
ex_flags  input  4  ALU flags {N,Z,C,V}, bit3 = N.
reg_flags  input  4  flag register output {N,Z,C,V}.
br_taken  output  1  one-cycle pulse: redirect fetch.
br_target  output  ADDR_W  registered target; valid while br_taken = 1.
flush_if  output  1  one-cycle pulse, coincident with br_taken.
squash_active  output  1  high while in SQUASH state.

Behaviour:
- Reset (reset = 0, asynchronous):
  - br_taken = 0, flush_if = 0, br_target = 0, squash_active = 0.
  - State = IDLE; counters cleared.
  - Takes effect mid-cycle and overrides any pending decision.
- Flag select (combinational): eff = ex_set_flags ? ex_flags : reg_flags.
- Condition decode (id_cond):
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !(C&!Z); 10 GE N==V; 11 LT N!=V.
  - 12 GT !Z&(N==V); 13 LE !(!Z&(N==V)); 14 AL 1; 15 NV 1.
- Evaluation occurs when state = IDLE, id_valid = 1 and stall = 0.
  - take = type1, OR type2 & id_rt_zero, OR type3 & cond_true.
  - type 0 never takes.
- Latency: one cycle. If take is 1 at edge k, then during cycle k+1:
  - br_taken = 1, flush_if = 1, br_target = id_target sampled at edge k.
- br_taken and flush_if are single-cycle pulses; they never stay high two consecutive cycles.
- When not taken, br_target holds its last value.
- State machine:
  - IDLE -> SQUASH on take.
  - IDLE -> IDLE otherwise.
  - SQUASH -> IDLE on the first edge with stall = 0.
  - SQUASH holds while stall = 1.
  - In SQUASH, ID inputs are ignored: a wrong-path branch never takes.
- stall = 1 in IDLE: no evaluation, no pulse, state unchanged.
- Simultaneous ex_set_flags = 1 and B.cond in ID: the forwarded ex_flags are used, never the stale reg_flags.
- stall does not extend a pulse already asserted; the pulse lasts exactly one cycle regardless of stall.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined:
  - Adds outputs br_resolved_cnt and br_taken_cnt (CNT_W each).
  - br_resolved_cnt increments per evaluated instruction with type != 0.
  - br_taken_cnt increments per take.
  - Both saturate at all-ones (no wrap) and clear on reset.
- Not defined: ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-pulse: drive reset = 0 during the cycle br_taken = 1 -> br_taken, flush_if, br_target = 0 immediately; state IDLE after release.
- Forwarding: reg_flags = 4'b0000, ex_set_flags = 1, ex_flags = 4'b0100, B.cond EQ, target 0x40 -> next cycle br_taken = 1, br_target = 0x40. Repeat with ex_set_flags = 0 -> not taken.
- Signed conditions: eff = 4'b1000 (N = 1, V = 0):
  - LT -> taken; GE -> not taken; LE -> taken.
  - eff = 4'b1001: GT -> taken.
- CBZ:
  - id_rt_zero = 1, target 0x100 -> taken with br_target = 0x100.
  - id_rt_zero = 0 -> br_taken stays 0.
- Squash with stall: B taken at edge k; a B.cond AL arrives in ID with stall = 1 for 2 cycles, then stall = 0.
  - Required: no second br_taken; squash_active high for 3 cycles; br_taken/flush_if high exactly 1 cycle.
- BRU_PERF_CNT_EN with CNT_W = 4: issue 20 taken unconditional branches, each separated by one squash cycle -> both counters saturate at 15.
